traffic_burst_scheduler: RTL and testbench

//  Sequences the GMII frame engine: decides when each frame starts, groups frames into bursts,

---
 rtl/traffic_burst_scheduler_pkg.sv | 20 ++
 rtl/traffic_burst_scheduler_tg_gap_timer.sv | 38 +++
 rtl/traffic_burst_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_traffic_burst_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_burst_scheduler_pkg.sv
// Shared types and defaults for the traffic generator burst scheduler.
package traffic_burst_scheduler_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam int unsigned LEN_WIDTH_DEF = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/traffic_burst_scheduler_tg_gap_timer.sv
// Load/value/expired down-counter, shared by the generator blocks for gap timing.
// The counter stops at zero; expired is high whenever the count is zero.
module tg_gap_timer
  import traffic_burst_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: reload on request, otherwise count down towards zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/traffic_burst_scheduler.sv
// Frame sequencer between the register block and the GMII frame engine.
//
//   state | meaning
//   IDLE  | stopped, waiting for an enable rise
//   ARM   | capture configuration into shadow registers, validate frame size
//   REQ   | frm_req high until the engine acks
//   WAIT  | frame in flight, waiting for frm_done
//   GAP   | inter-frame / inter-burst gap running
//   DONE  | total frame count reached, waiting for enable low
module traffic_burst_scheduler
  import traffic_burst_scheduler_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] cfg_ifg,
  input  logic [CNT_WIDTH-1:0] cfg_ibg,
  input  logic [CNT_WIDTH-1:0] cfg_frames_per_burst,
  input  logic [CNT_WIDTH-1:0] cfg_total_frames,
  input  logic [LEN_WIDTH-1:0] cfg_frame_size,
  output logic                 frm_req,
  output logic [LEN_WIDTH-1:0] frm_len,
  input  logic                 frm_ack,
  input  logic                 frm_done,
  output logic                 busy,
  output logic                 run_done,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] frames_sent,
  output logic [CNT_WIDTH-1:0] bursts_sent
);

  state_e               state_q, state_d;
  logic                 enable_q, enable_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [CNT_WIDTH-1:0] frames_q, frames_d;
  logic [CNT_WIDTH-1:0] bursts_q, bursts_d;
  logic [CNT_WIDTH-1:0] burst_idx_q, burst_idx_d;
  logic [CNT_WIDTH-1:0] ifg_q, ifg_d, ibg_q, ibg_d, fpb_q, fpb_d, total_q, total_d;
  logic [LEN_WIDTH-1:0] size_q, size_d;

  logic                 tmr_load;
  logic [CNT_WIDTH-1:0] tmr_value;
  logic                 tmr_expired;

  logic                 enable_rise;
  logic [CNT_WIDTH-1:0] frames_inc;
  logic                 burst_close;
  logic                 last_frame;
  logic [CNT_WIDTH-1:0] sel_gap;

  assign enable_rise = enable & ~enable_q;
  assign frames_inc  = frames_q + CNT_WIDTH'(1);
  assign burst_close = (fpb_q != '0) && ((burst_idx_q + CNT_WIDTH'(1)) == fpb_q);
  assign last_frame  = (total_q != '0) && (frames_inc == total_q);
  assign sel_gap     = burst_close ? ibg_q : ifg_q;

  tg_gap_timer #(.WIDTH(CNT_WIDTH)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // Next-state, shadow capture, counters and gap timer control.
  always_comb begin
    state_d     = state_q;
    enable_d    = enable;
    cfg_err_d   = cfg_err_q;
    frames_d    = frames_q;
    bursts_d    = bursts_q;
    burst_idx_d = burst_idx_q;
    ifg_d       = ifg_q;
    ibg_d       = ibg_q;
    fpb_d       = fpb_q;
    total_d     = total_q;
    size_d      = size_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;

    case (state_q)
      ST_IDLE: begin
        if (enable_rise) begin
          frames_d    = '0;
          bursts_d    = '0;
          burst_idx_d = '0;
          cfg_err_d   = 1'b0;
          state_d     = ST_ARM;
        end
      end
      ST_ARM: begin
        ifg_d   = cfg_ifg;
        ibg_d   = cfg_ibg;
        fpb_d   = cfg_frames_per_burst;
        total_d = cfg_total_frames;
        size_d  = cfg_frame_size;
        if (cfg_frame_size == '0) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (frm_ack) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (frm_done) begin
          frames_d = frames_inc;
          if (burst_close) begin
            bursts_d    = bursts_q + CNT_WIDTH'(1);
            burst_idx_d = '0;
          end else begin
            burst_idx_d = burst_idx_q + CNT_WIDTH'(1);
          end
          // The done cycle itself counts as one gap cycle, so a zero gap
          // goes straight back to REQ and the timer is loaded with gap-1.
          if (last_frame) begin
            state_d = ST_DONE;
          end else if (!enable) begin
            state_d = ST_IDLE;
          end else if (sel_gap == '0) begin
            state_d = ST_REQ;
          end else begin
            tmr_load  = 1'b1;
            tmr_value = sel_gap - CNT_WIDTH'(1);
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          state_d = enable ? ST_REQ : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shadow configuration and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      frames_q    <= '0;
      bursts_q    <= '0;
      burst_idx_q <= '0;
      ifg_q       <= '0;
      ibg_q       <= '0;
      fpb_q       <= '0;
      total_q     <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      cfg_err_q   <= cfg_err_d;
      frames_q    <= frames_d;
      bursts_q    <= bursts_d;
      burst_idx_q <= burst_idx_d;
      ifg_q       <= ifg_d;
      ibg_q       <= ibg_d;
      fpb_q       <= fpb_d;
      total_q     <= total_d;
      size_q      <= size_d;
    end
  end

  assign frm_req     = (state_q == ST_REQ);
  assign frm_len     = (state_q == ST_REQ) ? size_q : '0;
  assign busy        = state_is_busy(state_q);
  assign run_done    = (state_q == ST_DONE);
  assign cfg_err     = cfg_err_q;
  assign frames_sent = frames_q;
  assign bursts_sent = bursts_q;

endmodule

// File: tb/tb_traffic_burst_scheduler.sv
// Self-checking bench for traffic_burst_scheduler with a behavioural engine model.
module tb_traffic_burst_scheduler;

  localparam int CW = 32;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] cfg_ifg, cfg_ibg, cfg_fpb, cfg_total;
  logic [LW-1:0] cfg_size;
  logic          frm_req;
  logic [LW-1:0] frm_len;
  logic          frm_ack, frm_done;
  logic          busy, run_done, cfg_err;
  logic [CW-1:0] frames_sent, bursts_sent;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  traffic_burst_scheduler #(.CNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .cfg_ifg              (cfg_ifg),
    .cfg_ibg              (cfg_ibg),
    .cfg_frames_per_burst (cfg_fpb),
    .cfg_total_frames     (cfg_total),
    .cfg_frame_size       (cfg_size),
    .frm_req              (frm_req),
    .frm_len              (frm_len),
    .frm_ack              (frm_ack),
    .frm_done             (frm_done),
    .busy                 (busy),
    .run_done             (run_done),
    .cfg_err              (cfg_err),
    .frames_sent          (frames_sent),
    .bursts_sent          (bursts_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  // Program a config, make sure enable is low long enough, then raise it.
  task automatic start_run(input int unsigned ifg, ibg, fpb, total, size);
    enable    = 1'b0;
    cfg_ifg   = ifg;
    cfg_ibg   = ibg;
    cfg_fpb   = fpb;
    cfg_total = total;
    cfg_size  = size[LW-1:0];
    tick();
    tick();
    enable = 1'b1;
    tick();
    n_cmp++;
    if (frm_req !== 1'b0 || busy !== 1'b1 || cfg_err !== 1'b0 ||
        frames_sent !== '0 || bursts_sent !== '0) begin
      n_bad++;
      $display("FAIL start_arm: req=%0b busy=%0b err=%0b frames=%0d bursts=%0d, need 0/1/0/0/0",
               frm_req, busy, cfg_err, frames_sent, bursts_sent);
    end
  endtask

  // Runs n_run frames. Expected gaps and counts come from the frame index:
  // frame k closes a burst when fpb!=0 and k is a multiple of fpb.
  task automatic run_frames(input string nm, input int unsigned ifg, ibg, fpb, total, size,
                            n_run, stop_mode, ack_lo, ack_hi, done_lo, done_hi,
                            new_ifg_en, new_ifg);
    int unsigned last_done, t, ad, dd, exp_gap, exp_bursts;
    bit ok;
    last_done = 0;
    start_run(ifg, ibg, fpb, total, size);
    tick();
    n_cmp++;
    if (frm_req !== 1'b1 || frm_len !== size[LW-1:0]) begin
      n_bad++;
      $display("FAIL %s req_latency: req=%0b len=%0d, need 1/%0d", nm, frm_req, frm_len, size);
    end
    for (int k = 1; k <= int'(n_run); k++) begin
      t = 0;
      while (frm_req !== 1'b1 && t < 300) begin
        tick();
        t++;
      end
      n_cmp++;
      if (frm_req !== 1'b1) begin
        n_bad++;
        $display("FAIL %s req_timeout frame %0d: req=%0b, need 1", nm, k, frm_req);
        return;
      end
      if (k > 1) begin
        exp_gap = ((fpb != 0) && ((k - 1) % fpb == 0)) ? ibg : ifg;
        n_cmp++;
        if (cyc - last_done != exp_gap + 1) begin
          n_bad++;
          $display("FAIL %s gap frame %0d: %0d clk done->req, need %0d",
                   nm, k, cyc - last_done, exp_gap + 1);
        end
      end
      ok = (frm_len === size[LW-1:0]);
      ad = $urandom_range(ack_hi, ack_lo);
      repeat (ad) begin
        tick();
        if (frm_req !== 1'b1 || frm_len !== size[LW-1:0]) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s req_hold frame %0d: req=%0b len=%0d, need 1/%0d held %0d clk",
                 nm, k, frm_req, frm_len, size, ad);
      end
      frm_ack = 1'b1;
      tick();
      frm_ack = 1'b0;
      n_cmp++;
      if (frm_req !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s accept frame %0d: req=%0b busy=%0b, need 0/1", nm, k, frm_req, busy);
      end
      if (k == 1 && new_ifg_en != 0) cfg_ifg = new_ifg;
      dd = $urandom_range(done_hi, done_lo);
      repeat (dd) tick();
      if (k == int'(n_run) && stop_mode == 1) begin
        enable = 1'b0;
        tick();
      end
      if (k == int'(n_run) && stop_mode == 2) enable = 1'b0;
      frm_done  = 1'b1;
      last_done = cyc;
      tick();
      frm_done = 1'b0;
      exp_bursts = (fpb != 0) ? k / fpb : 0;
      n_cmp++;
      if (frames_sent !== k || bursts_sent !== exp_bursts) begin
        n_bad++;
        $display("FAIL %s counts frame %0d: frames=%0d bursts=%0d, need %0d/%0d",
                 nm, k, frames_sent, bursts_sent, k, exp_bursts);
      end
    end
    if (total != 0 && n_run == total) begin
      n_cmp++;
      if (run_done !== 1'b1 || busy !== 1'b0 || frm_req !== 1'b0) begin
        n_bad++;
        $display("FAIL %s run_done: done=%0b busy=%0b req=%0b, need 1/0/0", nm, run_done, busy, frm_req);
      end
    end else if (stop_mode != 0) begin
      n_cmp++;
      if (busy !== 1'b0 || run_done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s stop: busy=%0b done=%0b, need 0/0", nm, busy, run_done);
      end
    end
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (frm_req !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s quiet: frm_req seen after run end, need none", nm);
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (run_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s release: done=%0b busy=%0b, need 0/0", nm, run_done, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({frm_req, frm_len, busy, run_done, cfg_err, frames_sent, bursts_sent} !== '0) begin
      n_bad++;
      $display("FAIL reset: req=%0b len=%0d busy=%0b done=%0b err=%0b frames=%0d bursts=%0d, need all 0",
               frm_req, frm_len, busy, run_done, cfg_err, frames_sent, bursts_sent);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_and_bursts();
    run_frames("t1_ifg", 10, 0, 0, 3, 64, 3, 0, 0, 0, 63, 63, 0, 0);
    run_frames("t2_burst", 2, 20, 4, 8, 300, 8, 0, 0, 2, 1, 6, 0, 0);
  endtask

  task automatic test_graceful_stop();
    run_frames("t3_stop", 1, 0, 0, 0, 128, 5, 1, 0, 1, 2, 5, 0, 0);
    run_frames("t3_stop_sim", 0, 4, 2, 0, 77, 4, 2, 0, 1, 0, 3, 0, 0);
  endtask

  task automatic test_ack_delay_cfg_change();
    run_frames("t4_ackdly", 5, 9, 0, 3, 1500, 3, 0, 6, 6, 2, 4, 1, 1);
  endtask

  task automatic test_cfg_err();
    bit ok;
    start_run(3, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || frm_req !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_err: err=%0b busy=%0b req=%0b, need 1/0/0", cfg_err, busy, frm_req);
    end
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (frm_req !== 1'b0) ok = 1'b0;
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (!ok || cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL t5_sticky: req_quiet=%0b err=%0b, need 1/1", ok, cfg_err);
    end
    run_frames("t5_rerun", 3, 0, 0, 2, 64, 2, 0, 0, 1, 1, 3, 0, 0);
  endtask

  task automatic test_async_reset();
    start_run(20, 0, 0, 0, 100);
    tick();
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
    #2 rst = 1'b1;
    enable = 1'b0;
    #1;
    n_cmp++;
    if ({frm_req, frm_len, busy, run_done, cfg_err, frames_sent, bursts_sent} !== '0) begin
      n_bad++;
      $display("FAIL t6_rst_wait: req=%0b busy=%0b frames=%0d, need all 0", frm_req, busy, frames_sent);
    end
    tick();
    rst = 1'b0;
    tick();
    start_run(20, 0, 0, 0, 100);
    tick();
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
    frm_done = 1'b1;
    tick();
    frm_done = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b1 || frm_req !== 1'b0 || frames_sent !== 1) begin
      n_bad++;
      $display("FAIL t6_in_gap: busy=%0b req=%0b frames=%0d, need 1/0/1", busy, frm_req, frames_sent);
    end
    #2 rst = 1'b1;
    enable = 1'b0;
    #1;
    n_cmp++;
    if ({frm_req, frm_len, busy, run_done, cfg_err, frames_sent, bursts_sent} !== '0) begin
      n_bad++;
      $display("FAIL t6_rst_gap: busy=%0b frames=%0d, need all 0", busy, frames_sent);
    end
    tick();
    rst = 1'b0;
    tick();
    run_frames("t6_restart", 1, 3, 2, 4, 200, 4, 0, 0, 2, 0, 3, 0, 0);
  endtask

  task automatic test_random_runs();
    int unsigned ifg, ibg, fpb, total, size, n_run, stop_mode;
    for (int r = 0; r < 10; r++) begin
      ifg       = $urandom_range(6, 0);
      ibg       = $urandom_range(15, 0);
      fpb       = $urandom_range(4, 0);
      size      = $urandom_range(2047, 1);
      stop_mode = $urandom_range(2, 0);
      if (stop_mode == 0) begin
        total = $urandom_range(9, 1);
        n_run = total;
      end else begin
        total = 0;
        n_run = $urandom_range(7, 1);
      end
      run_frames($sformatf("rnd%0d", r), ifg, ibg, fpb, total, size, n_run, stop_mode,
                 0, 3, 0, 5, 0, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_ifg   = '0;
    cfg_ibg   = '0;
    cfg_fpb   = '0;
    cfg_total = '0;
    cfg_size  = '0;
    frm_ack   = 1'b0;
    frm_done  = 1'b0;
    test_reset();
    test_basic_and_bursts();
    test_graceful_stop();
    test_ack_delay_cfg_change();
    test_cfg_err();
    test_async_reset();
    test_random_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
